// File: rtl/tc_pkg.sv
// Shared types for the tile matrix-multiply arbiter slice.
//   fp16_t / fp32_t     : raw IEEE half / single bit patterns (never interpreted here)
//   tile16_t / tile32_t : 4x4 tiles, element index = 4*row + col
//   arb_state_t         : arbiter FSM state
//   TILE_ELEMS          : elements per tile
//   MAX_DP_LAT          : largest supported datapath latency, sizes the latency timer
package tc_pkg;

  localparam int TILE_ELEMS = 16;
  localparam int MAX_DP_LAT = 15;

  typedef logic [15:0] fp16_t;
  typedef logic [31:0] fp32_t;

  typedef fp16_t [TILE_ELEMS-1:0] tile16_t;
  typedef fp32_t [TILE_ELEMS-1:0] tile32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker.
// Scans the valid vector starting at ptr, wrapping modulo N, and picks the
// first set index.
//   valid     in  N      request vector
//   ptr       in  IDX_W  index with highest priority this cycle (must be < N)
//   grant     out N      one-hot grant, all zero when nothing is valid
//   idx       out IDX_W  encoded grant index, 0 when nothing is valid
//   any_valid out 1      at least one valid bit set
module rr_grant
  import tc_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  localparam int SUM_W = IDX_W + 1;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [SUM_W-1:0] sum;

  always_comb begin
    // rot[k] is valid[(ptr + k) mod N]; rotating a doubled copy avoids
    // computed bit indices.
    rot       = N'({valid, valid} >> ptr);
    off       = '0;
    any_valid = 1'b0;
    // Descending scan so the lowest set offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off       = IDX_W'(k);
        any_valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SUM_W'(N)) begin
      sum = sum - SUM_W'(N);
    end
    idx   = any_valid ? sum[IDX_W-1:0] : '0;
    grant = any_valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mm_tile_arbiter.sv
// Shares one 4x4 FP16-in / FP32-out matrix-multiply datapath among NREQ
// requesters. Whole A/B tiles are accepted round-robin, registered into the
// datapath, the result is captured after DP_LAT cycles and returned with the
// owner id on a single valid/ready response channel. One job in flight.
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    per-requester job handshake
//   req_a, req_b       per-requester operand tiles
//   rsp_valid/ready    result handshake
//   rsp_id, rsp_c      owner of the result and the result tile
//   mm_a, mm_b         registered operands driven into the datapath
//   mm_c               datapath result
//   busy               state is not IDLE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | offering a grant to the round-robin winner
//   WAIT  | operands registered, lat_cnt counting down datapath latency
//   RESP  | result held on rsp_* until rsp_ready
module mm_tile_arbiter
  import tc_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DP_LAT = 0,
  parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  tile16_t [NREQ-1:0]  req_a,
  input  tile16_t [NREQ-1:0]  req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output tile32_t             rsp_c,
  output tile16_t             mm_a,
  output tile16_t             mm_b,
  input  tile32_t             mm_c,
  output logic                busy
);

  localparam int LAT_W = $clog2(MAX_DP_LAT + 1);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [LAT_W-1:0] lat_cnt;

  logic [NREQ-1:0]  grant_oh;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;

  rr_grant #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_rr_grant (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant_oh),
    .idx       (grant_idx),
    .any_valid (grant_any)
  );

  // The picker only selects valid requesters, so a grant in IDLE is the
  // handshake. Gating with rst keeps a reset cycle from looking like an accept.
  assign req_ready = ((state == IDLE) && !rst) ? grant_oh : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      mm_a      <= '0;
      mm_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            mm_a    <= req_a[grant_idx];
            mm_b    <= req_b[grant_idx];
            rsp_id  <= grant_idx;
            lat_cnt <= LAT_W'(DP_LAT);
            if (grant_idx == ID_W'(NREQ - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= grant_idx + 1'b1;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            rsp_c     <= mm_c;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mm_tile_arbiter.md
Name: mm_tile_arbiter

Overview:
- Shares one 4x4 FP16-in/FP32-out matrix-multiply datapath among NREQ requesters.
- Accepts whole A/B operand tiles over per-requester valid/ready and grants round-robin.
- Registers the operands into the datapath, waits the datapath latency, captures the 16 FP32 results and returns them with the requester id over a single valid/ready response channel.
- Sits between the tile-fetch front ends and the matrix-multiply datapath. One job is in flight at a time.

Parameters:
- NREQ, 4, number of requesters, legal range 1..8.
- DP_LAT, 0, datapath latency in cycles from operand registers to a valid mm_c, legal range 0..15. 0 means a purely combinational datapath.
- ID_W, max(1,$clog2(NREQ)), width of the requester id. Derived; must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester job accept.
- req_a  in  NREQ x 16 x 16  A tile per requester, element index = 4*row+col, FP16.
- req_b  in  NREQ x 16 x 16  B tile per requester, same indexing, FP16.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_c  out  16 x 32  result tile, FP32, as delivered by the datapath.
- mm_a  out  16 x 16  registered A operands to the datapath.
- mm_b  out  16 x 16  registered B operands to the datapath.
- mm_c  in  16 x 32  datapath result.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values, applied on the first rising edge with rst high:
  - state IDLE, rr_ptr 0, lat_cnt 0.
  - req_ready all 0, rsp_valid 0, rsp_id 0, rsp_c all 0, mm_a and mm_b all 0, busy 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Combinational grant: scan from rr_ptr upward, wrapping modulo NREQ; pick the first index with req_valid set.
  - req_ready is asserted only for the granted index; all other bits are 0. req_ready is 0 in every other state.
  - Handshake is req_valid[g] & req_ready[g]. On the handshake edge:
    - mm_a <= req_a[g], mm_b <= req_b[g], rsp_id <= g.
    - rr_ptr <= (g+1) mod NREQ, lat_cnt <= DP_LAT.
    - Go to WAIT.
- WAIT:
  - If lat_cnt != 0, decrement it.
  - If lat_cnt == 0: rsp_c <= mm_c, rsp_valid <= 1, go to RESP.
  - Latency: the handshake in cycle t gives rsp_valid high in cycle t+DP_LAT+2.
- RESP:
  - rsp_valid, rsp_id and rsp_c are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - No grant occurs in the same cycle as a response handshake. Minimum job spacing is DP_LAT+3 cycles.
- Register contents after a job:
  - mm_a and mm_b keep the last operands; they are not cleared.
  - rsp_c keeps its last value after rsp_valid drops.
- Requester contract: req_valid and the tile data stay stable until accepted. The block samples data only on the handshake edge.
- A requester dropping req_valid before grant is legal; it simply loses arbitration.
- NREQ=1: the grant is always 0, rr_ptr stays 0, and rsp_id is 1 bit wide, always 0.
- Reset mid-operation, in any state: on the next edge every register returns to its reset value.
  - The in-flight job is discarded and no response is produced.
  - The requester must re-present its job.
- rst overrides every handshake in the same cycle.
- busy = (state != IDLE), driven from registered state.
- Arithmetic: none inside this block. FP values pass through bit-exact.

Decomposition:
- Shared package tc_pkg holds:
  - fp16_t (logic [15:0]) and fp32_t (logic [31:0]).
  - tile16_t (fp16_t [16]) and tile32_t (fp32_t [16]).
  - The state enum {IDLE, WAIT, RESP}.
  - Constants TILE_ELEMS=16 and MAX_DP_LAT=15.
- One sub-module, rr_grant: a combinational round-robin picker.
  - Inputs: valid vector and rr_ptr.
  - Outputs: one-hot grant, encoded index and any_valid.
  - It is reused by future arbiters.

Test Plan:
- Single job, DP_LAT=0, NREQ=4:
  - Stimulus: requester 2, A = identity (diagonal 16'h3C00, rest 0), B all 16'h4000, rsp_ready=1.
  - Required: req_ready=4'b0100 in the handshake cycle, rsp_valid 2 cycles later, rsp_id=2, all rsp_c=32'h40000000, busy high in between.
- All four requesters valid from reset release, rsp_ready=1, DP_LAT=0:
  - Required: grants in order 0,1,2,3, spaced exactly 3 cycles apart, with rsp_id sequence 0,1,2,3.
- Backpressure:
  - Stimulus: rsp_ready held 0 for 10 cycles while requesters 1 and 3 are valid.
  - Required: rsp_valid, rsp_id and rsp_c stay constant; req_ready=0 throughout; the next grant comes one cycle after the response handshake.
- Fairness:
  - Stimulus: requester 0 continuously valid; requester 3 raises req_valid while the job from requester 0 is in WAIT.
  - Required: the next grant goes to 3, then to 0.
- Reset mid-WAIT, DP_LAT=4:
  - Stimulus: assert rst for 1 cycle, 2 cycles after the handshake.
  - Required: the next cycle shows all outputs at reset values; rsp_valid never rises for that job; the next grant starts the scan from 0.
- DP_LAT=3, with a model datapath that delays by 3 registers:
  - Required: rsp_valid 5 cycles after the handshake, and rsp_c equals the model result, not the stale mm_c of earlier cycles.
